// File: rtl/position_stepper.sv
// Sprite position stepper: advances X/Y once per frame tick at a fixed-point speed,
// buffers turns until tile-aligned, stops at walls and wraps x through the tunnel.
module position_stepper #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SPEED_W = 8,
    parameter int unsigned FRAC_W  = 4,
    parameter int unsigned TILE    = 8,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 223,
    parameter int unsigned X_START = 112,
    parameter int unsigned Y_START = 188
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [3:0]         req_dir,
    input  logic [3:0]         legal_moves,
    input  logic [SPEED_W-1:0] speed,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic [3:0]         cur_dir,
    output logic               moving,
    output logic               turned
);
    localparam int unsigned SUM_W  = SPEED_W + 1;
    localparam int unsigned STEP_W = SUM_W - FRAC_W;
    localparam int unsigned SW     = COORD_W + 2;

    localparam logic signed [SW-1:0] TILE_S = SW'(TILE);
    localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] ONE_S  = SW'(1);
    localparam logic [COORD_W-1:0]   TMASK  = COORD_W'(TILE - 1);

    typedef enum logic {ST_STOP, ST_MOVE} state_t;

    state_t              state, state_next;
    logic [FRAC_W-1:0]   acc, acc_next;
    logic [3:0]          pending, pend_next;
    logic [COORD_W-1:0]  x_next, y_next;
    logic [3:0]          dir_next;
    logic                turned_next;

    logic [SUM_W-1:0]    sum;
    logic [STEP_W-1:0]   step;
    logic                pend_legal;
    logic                aligned;
    logic                do_move;
    logic                adopt;
    logic                horiz;
    logic                neg;
    logic signed [SW-1:0] moved;

    function automatic logic [3:0] lowest_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // Bit order is left, right, up, down: opposites are adjacent pairs.
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // Move along one axis, stopping on the first tile centre strictly inside the step.
    function automatic logic signed [SW-1:0] advance(input logic [COORD_W-1:0] p,
                                                     input logic [STEP_W-1:0]  s,
                                                     input logic               dec);
        logic signed [SW-1:0] ps;
        logic signed [SW-1:0] ss;
        logic signed [SW-1:0] base;
        logic signed [SW-1:0] centre;
        logic signed [SW-1:0] res;
        ps   = $signed(SW'(p));
        ss   = $signed(SW'(s));
        base = $signed(SW'(p & ~TMASK));
        if (dec) begin
            centre = (base == ps) ? base - TILE_S : base;
            res    = ps - ss;
            if (centre > res) res = centre;
        end else begin
            centre = base + TILE_S;
            res    = ps + ss;
            if (centre < res) res = centre;
        end
        return res;
    endfunction

    function automatic logic [COORD_W-1:0] wrap_x(input logic signed [SW-1:0] r,
                                                  input logic               dec);
        logic signed [SW-1:0] w;
        w = r;
        if (dec && (r < XMIN_S))
            w = XMAX_S - (XMIN_S - r - ONE_S);
        else if (!dec && (r > XMAX_S))
            w = XMIN_S + (r - XMAX_S - ONE_S);
        return COORD_W'(w);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_STOP;
            xpos    <= COORD_W'(X_START);
            ypos    <= COORD_W'(Y_START);
            cur_dir <= '0;
            acc     <= '0;
            pending <= '0;
            moving  <= 1'b0;
            turned  <= 1'b0;
        end else begin
            state   <= state_next;
            xpos    <= x_next;
            ypos    <= y_next;
            cur_dir <= dir_next;
            acc     <= acc_next;
            pending <= pend_next;
            moving  <= (state_next == ST_MOVE);
            turned  <= turned_next;
        end
    end

    always_comb begin
        state_next  = state;
        x_next      = xpos;
        y_next      = ypos;
        dir_next    = cur_dir;
        acc_next    = acc;
        pend_next   = pending;
        turned_next = 1'b0;
        do_move     = 1'b0;
        adopt       = 1'b0;

        sum        = SUM_W'(acc) + SUM_W'(speed);
        step       = STEP_W'(sum >> FRAC_W);
        pend_legal = |(pending & legal_moves);
        aligned    = (cur_dir[0] | cur_dir[1]) ? ((xpos & TMASK) == '0)
                                               : ((ypos & TMASK) == '0);

        if (load) begin
            state_next = ST_STOP;
            x_next     = load_x;
            y_next     = load_y;
            dir_next   = '0;
            acc_next   = '0;
            pend_next  = '0;
        end else begin
            if (tick) begin
                if (state == ST_STOP) begin
                    if (pend_legal) begin
                        state_next  = ST_MOVE;
                        dir_next    = pending;
                        turned_next = 1'b1;
                        adopt       = 1'b1;
                        do_move     = 1'b1;
                        acc_next    = sum[FRAC_W-1:0];
                    end
                end else begin
                    acc_next = sum[FRAC_W-1:0];
                    do_move  = 1'b1;
                    // Reversal needs neither alignment nor legality and is not a centre turn.
                    if ((pending != '0) && (pending == opposite(cur_dir))) begin
                        dir_next = pending;
                        adopt    = 1'b1;
                    end else if (aligned) begin
                        if (pend_legal && (pending != cur_dir)) begin
                            dir_next    = pending;
                            adopt       = 1'b1;
                            turned_next = 1'b1;
                        end else if (!(|(cur_dir & legal_moves))) begin
                            state_next = ST_STOP;
                            dir_next   = '0;
                            acc_next   = '0;
                            do_move    = 1'b0;
                        end
                    end
                end
            end
            if (adopt) pend_next = '0;
            if (|req_dir) pend_next = lowest_bit(req_dir);
        end

        horiz = dir_next[0] | dir_next[1];
        neg   = dir_next[0] | dir_next[2];
        moved = advance(horiz ? xpos : ypos, step, neg);
        if (do_move) begin
            if (horiz) x_next = wrap_x(moved, neg);
            else       y_next = COORD_W'(moved);
        end
    end

endmodule

// File: tb/tb_position_stepper.sv
// Bench for position_stepper: directed movement scenarios plus randomized traffic
// compared every cycle against an integer reference model.
module tb_position_stepper;
    localparam int TILE    = 8;
    localparam int X_MIN   = 0;
    localparam int X_MAX   = 223;
    localparam int X_START = 112;
    localparam int Y_START = 188;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       load;
    logic [9:0] load_x;
    logic [9:0] load_y;
    logic [3:0] req_dir;
    logic [3:0] legal_moves;
    logic [7:0] speed;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [3:0] cur_dir;
    logic       moving;
    logic       turned;

    int checks   = 0;
    int failures = 0;

    // Reference model state: directions as indices 0=left 1=right 2=up 3=down, -1 = none.
    int mx, my, mdir, macc, mpend;
    bit mmov, mturn;

    int half_exp[5] = '{112, 113, 113, 114, 114};
    int speed_tab[6] = '{0, 8, 16, 24, 32, 48};

    position_stepper dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_x(load_x), .load_y(load_y), .req_dir(req_dir),
        .legal_moves(legal_moves), .speed(speed),
        .xpos(xpos), .ypos(ypos), .cur_dir(cur_dir),
        .moving(moving), .turned(turned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mod_t(input int v);
        return ((v % TILE) + TILE) % TILE;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mx = X_START; my = Y_START; mdir = -1; macc = 0; mpend = -1;
        mmov = 0; mturn = 0;
    endtask

    task automatic model_move(input int dirc, input int stp);
        int d, p, t;
        bit hz;
        hz = (dirc < 2);
        d  = (dirc == 0 || dirc == 2) ? -1 : 1;
        p  = hz ? mx : my;
        t  = p + d * stp;
        for (int k = 1; k < stp; k++) begin
            if (mod_t(p + d * k) == 0) begin
                t = p + d * k;
                break;
            end
        end
        if (hz) begin
            if (d < 0 && t < X_MIN)      t = X_MAX - (X_MIN - t - 1);
            else if (d > 0 && t > X_MAX) t = X_MIN + (t - X_MAX - 1);
            mx = t;
        end else begin
            my = ((t % 1024) + 1024) % 1024;
        end
    endtask

    task automatic model_step();
        int sum, stp;
        bit adopted, go, nturn, algn;
        if (load) begin
            mx = int'(load_x); my = int'(load_y); mdir = -1; mmov = 0;
            macc = 0; mpend = -1; mturn = 0;
            return;
        end
        sum = macc + int'(speed);
        stp = sum / 16;
        adopted = 0; go = 0; nturn = 0;
        if (tick) begin
            if (!mmov) begin
                if (mpend >= 0 && legal_moves[mpend]) begin
                    mdir = mpend; mmov = 1; nturn = 1; adopted = 1; go = 1;
                    macc = sum % 16;
                end
            end else begin
                macc = sum % 16;
                go   = 1;
                algn = (mod_t(mdir < 2 ? mx : my) == 0);
                if (mpend >= 0 && mpend == (mdir ^ 1)) begin
                    mdir = mpend; adopted = 1;
                end else if (algn) begin
                    if (mpend >= 0 && legal_moves[mpend] && mpend != mdir) begin
                        mdir = mpend; adopted = 1; nturn = 1;
                    end else if (!legal_moves[mdir]) begin
                        mdir = -1; mmov = 0; macc = 0; go = 0;
                    end
                end
            end
        end
        if (adopted) mpend = -1;
        if (req_dir != 4'b0) mpend = lowest(req_dir);
        if (go) model_move(mdir, stp);
        mturn = nturn;
    endtask

    task automatic check_all();
        check_val("xpos", int'(xpos), mx);
        check_val("ypos", int'(ypos), my);
        check_val("cur_dir", int'(cur_dir), (mdir < 0) ? 0 : (1 << mdir));
        check_val("moving", int'(moving), int'(mmov));
        check_val("turned", int'(turned), int'(mturn));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_req(input logic [3:0] r);
        tick = 1'b0; req_dir = r;
        cycle();
        req_dir = 4'b0;
    endtask

    task automatic do_load(input int x, input int y);
        load = 1'b1; load_x = 10'(x); load_y = 10'(y);
        cycle();
        load = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; load = 1'b0; load_x = '0; load_y = '0;
        req_dir = '0; legal_moves = '0; speed = '0;
        model_reset();
        #3;
        check_all();
        check_val("rst_x", int'(xpos), 112);
        check_val("rst_y", int'(ypos), 188);
        #4 rst = 1'b0;

        // Start from STOP at 1.0 px per tick.
        speed = 8'd16; legal_moves = 4'b0011;
        set_req(4'b0010);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("start_x", int'(xpos), 113 + i);
            check_val("start_turned", int'(turned), int'(i == 0));
        end
        tick = 1'b0;

        // Half-pixel speed.
        speed = 8'd8;
        do_load(112, 188);
        set_req(4'b0010);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("half_x", int'(xpos), half_exp[i]);
        end
        tick = 1'b0;

        // Centre clamp then buffered turn up.
        speed = 8'd48; legal_moves = 4'b0111;
        do_load(118, 188);
        set_req(4'b0010);
        tick_once();
        check_val("clamp_x", int'(xpos), 120);
        set_req(4'b0100);
        tick_once();
        check_val("turn_up_turned", int'(turned), 1);
        check_val("turn_up_y", int'(ypos), 185);
        check_val("turn_up_dir", int'(cur_dir), 4);

        // Reversal away from a centre.
        legal_moves = 4'b0011;
        do_load(113, 188);
        set_req(4'b0010);
        tick_once();
        check_val("rev_pre_x", int'(xpos), 116);
        set_req(4'b0001);
        tick_once();
        check_val("rev_dir", int'(cur_dir), 1);
        check_val("rev_x", int'(xpos), 113);
        check_val("rev_turned", int'(turned), 0);

        // Tunnel wrap both ways.
        speed = 8'd32; legal_moves = 4'b0001;
        do_load(0, 100);
        set_req(4'b0001);
        tick_once();
        check_val("wrap_left_x", int'(xpos), 222);
        legal_moves = 4'b0010;
        do_load(222, 100);
        set_req(4'b0010);
        tick_once();
        check_val("wrap_right_x", int'(xpos), 0);

        // Wall stop at a centre.
        legal_moves = 4'b0001;
        do_load(123, 96);
        set_req(4'b0001);
        tick_once();
        tick_once();
        check_val("stop_pre_x", int'(xpos), 120);
        legal_moves = 4'b0100;
        tick_once();
        check_val("stop_dir", int'(cur_dir), 0);
        check_val("stop_moving", int'(moving), 0);
        check_val("stop_x", int'(xpos), 120);

        // Asynchronous reset mid-motion, no clock edge.
        speed = 8'd16; legal_moves = 4'b0011;
        do_load(128, 188);
        set_req(4'b0010);
        tick = 1'b1;
        cycle();
        cycle();
        tick = 1'b0;
        check_val("arst_pre_x", int'(xpos), 130);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check_val("arst_x", int'(xpos), 112);
        check_val("arst_moving", int'(moving), 0);
        #1 rst = 1'b0;

        // Randomized traffic against the model.
        legal_moves = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            tick        = ($urandom_range(0, 99) < 60);
            load        = ($urandom_range(0, 99) < 3);
            load_x      = 10'($urandom_range(0, 223));
            load_y      = 10'($urandom_range(0, 300));
            req_dir     = ($urandom_range(0, 99) < 15) ? 4'($urandom) : 4'b0;
            legal_moves = ($urandom_range(0, 99) < 70) ? legal_moves : 4'($urandom);
            if ($urandom_range(0, 99) < 5) begin
                if ($urandom_range(0, 1) == 0) speed = 8'(speed_tab[$urandom_range(0, 5)]);
                else                           speed = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        tick = 1'b0; load = 1'b0; req_dir = 4'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
